axis_fifo_sync_param: RTL and testbench
=======================================

Name: axis_fifo_sync_param

Overview:
- Parametrised successor of the fixed 16-bit synchronous AXI-Stream FIFO.
- Single-clock, first-word-fall-through FIFO with configurable data width, depth and almost-full threshold.
- Exposes occupancy and watermark status to upstream flow control.
- Sits between AXI-Stream producer and consumer stages in the same clock domain.

Parameters:
- DATA_WIDTH, 16, tdata width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- AF_THRESH, DEPTH-2, almost_full asserts when fill_count >= AF_THRESH (1..DEPTH)

Ports:
- s_axis_aclk  input  1  sole clock; all logic on rising edge
- s_axis_areset  input  1  synchronous reset, active-high
- s_axis_tvalid  input  1  upstream beat valid
- s_axis_tready  output  1  FIFO can accept a beat
- s_axis_tdata  input  DATA_WIDTH  upstream data
- s_axis_tlast  input  1  upstream end of packet
- m_axis_tvalid  output  1  head beat valid
- m_axis_tready  input  1  downstream accepts head beat
- m_axis_tdata  output  DATA_WIDTH  head data
- m_axis_tlast  output  1  head end-of-packet flag
- fill_count  output  $clog2(DEPTH+1)  entries currently stored
- almost_full  output  1  fill_count >= AF_THRESH

Behaviour:
- Interface: one clock, s_axis_aclk; reset is synchronous and active-high, s_axis_areset.
- Storage: DEPTH x (DATA_WIDTH+1) array holding {tlast, tdata}.
  - Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Reset, sampled on the clock edge, clears pointers and fill_count to 0.
  - While s_axis_areset is high: s_axis_tready=0, m_axis_tvalid=0, almost_full=0 (AF_THRESH>=1).
  - m_axis_tdata/tlast are don't-care when m_axis_tvalid=0; the bench must not check them.
- Reset mid-operation discards all stored beats. A beat presented in the reset cycle is not accepted.
- Push occurs when s_axis_tvalid && s_axis_tready; pop occurs when m_axis_tvalid && m_axis_tready.
- s_axis_tready = !reset && (fill_count != DEPTH).
  - Registered-state based; no combinational path from m_axis_tready.
  - When full, a simultaneous pop does not enable a push in the same cycle.
- m_axis_tvalid = (fill_count != 0). FWFT: head entry is driven combinationally from the array at the read pointer.
- Latency: a beat pushed at edge N is visible on m_axis_* after edge N (1 cycle), including when the FIFO was empty. No bypass path.
- fill_count update per edge:
  - +1 on push only
  - -1 on pop only
  - unchanged on push and pop together, or on neither
- Push and pop together at non-empty, non-full: both pointers advance and count is unchanged.
- Empty: no pop is possible. Full: no push is possible.
- Input is sampled only on a push. Holding s_axis_tvalid while tready=0 has no effect.
- almost_full is derived combinationally from the registered fill_count.
- AXI-Stream rule: tdata/tlast/tvalid on the master side remain stable while tvalid=1 and tready=0, which follows from the FWFT head being unchanged without a pop.
- Illegal parameters (DEPTH not a power of two, AF_THRESH out of range) are caught by an elaboration-time $error.

Optional Feature:
- Macro AXIS_FIFO_PACKET_MODE_EN.
- When defined:
  - Maintain pkt_count, incremented on a push with tlast=1 and decremented on a pop with tlast=1.
  - If both happen in one cycle, pkt_count is unchanged.
  - m_axis_tvalid = (fill_count != 0) && (pkt_count != 0 || fill_count == DEPTH).
  - The full override prevents deadlock on packets longer than DEPTH.
  - pkt_count resets to 0.
- When not defined: plain FWFT as above, and no pkt_count logic is present.

Test Plan:
- Reset then idle, DEPTH=16 -> s_axis_tready=1, m_axis_tvalid=0, fill_count=0, almost_full=0 on the first cycle after reset deasserts.
- Push 0x0001..0x0010 with m_axis_tready=0 -> fill_count steps 1..16. almost_full rises when fill_count=14. s_axis_tready=0 at 16; a 17th beat 0xDEAD is not accepted.
- From full, assert m_axis_tready only -> data pops out in order 0x0001..0x0010 with tlast preserved. s_axis_tready returns to 1 the cycle after the first pop. m_axis_tvalid falls after 16 pops.
- Continuous push and pop with random valid/ready for 1000 beats (pointers wrap 60+ times) -> output sequence equals input sequence and fill_count never exceeds 16.
- With 5 beats stored, assert reset for 1 cycle while s_axis_tvalid=1 -> fill_count=0, m_axis_tvalid=0, and the presented beat is never output.
- With AXIS_FIFO_PACKET_MODE_EN: push 3 beats with tlast=0 -> m_axis_tvalid stays 0. Push a 4th beat with tlast=1 -> m_axis_tvalid=1 the next cycle. Push 16 beats with no tlast -> m_axis_tvalid=1 once full.

Source files
------------

// File: rtl/axis_fifo_sync_param.sv
// axis_fifo_sync_param
// Single-clock, first-word-fall-through AXI-Stream FIFO with configurable
// data width, depth and almost-full threshold. Occupancy (fill_count) and
// the almost_full watermark are exposed for upstream flow control.
//
// Optional build macro: AXIS_FIFO_PACKET_MODE_EN
//   When defined, the head beat is only offered downstream once a complete
//   packet (a beat with tlast=1) is stored, or when the FIFO is full. The
//   full override lets packets longer than DEPTH drain instead of deadlocking.
//   When undefined the FIFO is a plain FWFT queue with no packet tracking.
//
// Storage entries hold {tlast, tdata}. Pointers are $clog2(DEPTH) bits wide
// and wrap modulo DEPTH by natural overflow, which is why DEPTH must be a
// power of two.

module axis_fifo_sync_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2
) (
  input  logic                         s_axis_aclk,
  input  logic                         s_axis_areset,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic [$clog2(DEPTH+1)-1:0]   fill_count,
  output logic                         almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATA_WIDTH + 1;

  localparam logic [CNT_W-1:0] C_CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_AF   = CNT_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] C_PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("axis_fifo_sync_param: DATA_WIDTH must be >= 1");
  end

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("axis_fifo_sync_param: DEPTH must be a power of two and >= 2");
  end

  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
    $error("axis_fifo_sync_param: AF_THRESH must lie in 1..DEPTH");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [CNT_W-1:0] r_pkt_count;
`endif

  // ---------------------------------------------------------------------------
  // Derived wires
  // ---------------------------------------------------------------------------
  logic             w_full;
  logic             w_empty;
  logic             w_head_valid;
  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;

  // Occupancy flags and the FWFT head entry, all from registered state.
  always_comb begin
    w_full  = 1'b0;
    w_empty = 1'b0;
    w_head  = r_mem[r_rd_ptr];
    if (r_count == C_CNT_FULL) begin
      w_full = 1'b1;
    end else begin
      w_full = 1'b0;
    end
    if (r_count == C_CNT_ZERO) begin
      w_empty = 1'b1;
    end else begin
      w_empty = 1'b0;
    end
  end

  // Head-valid qualification: plain FWFT, or gated on a complete packet.
  always_comb begin
    w_head_valid = 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    if (!w_empty && ((r_pkt_count != C_CNT_ZERO) || w_full)) begin
      w_head_valid = 1'b1;
    end else begin
      w_head_valid = 1'b0;
    end
`else
    if (!w_empty) begin
      w_head_valid = 1'b1;
    end else begin
      w_head_valid = 1'b0;
    end
`endif
  end

  // Handshake outputs and watermark; everything is forced idle during reset.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    almost_full   = 1'b0;
    if (s_axis_areset) begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      almost_full   = 1'b0;
    end else begin
      s_axis_tready = !w_full;
      m_axis_tvalid = w_head_valid;
      almost_full   = (r_count >= C_CNT_AF);
    end
  end

  // Transfer qualifiers; tready depends only on state, so a pop never
  // opens room for a push in the same cycle.
  always_comb begin
    w_push = s_axis_tvalid && s_axis_tready;
    w_pop  = m_axis_tvalid && m_axis_tready;
  end

  // Head data and occupancy are presented straight from storage/state.
  always_comb begin
    m_axis_tdata = w_head[DATA_WIDTH-1:0];
    m_axis_tlast = w_head[DATA_WIDTH];
    fill_count   = r_count;
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Storage write: capture {tlast, tdata} only on an accepted beat.
  always_ff @(posedge s_axis_aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // Write pointer: advances on each push, wraps modulo DEPTH.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_wr_ptr <= C_PTR_ZERO;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
    end
  end

  // Read pointer: advances on each pop, wraps modulo DEPTH.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_rd_ptr <= C_PTR_ZERO;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  // Occupancy counter: +1 push only, -1 pop only, hold otherwise.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_count <= C_CNT_ZERO;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef AXIS_FIFO_PACKET_MODE_EN
  // Complete-packet counter: tracks stored beats carrying tlast=1.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_pkt_count <= C_CNT_ZERO;
    end else begin
      case ({w_push && s_axis_tlast, w_pop && w_head[DATA_WIDTH]})
        2'b10:   r_pkt_count <= r_pkt_count + C_CNT_ONE;
        2'b01:   r_pkt_count <= r_pkt_count - C_CNT_ONE;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_axis_fifo_sync_param.sv
// Self-checking bench for axis_fifo_sync_param (DATA_WIDTH=16, DEPTH=16,
// AF_THRESH=14). A queue-based reference model tracks stored beats; a
// negedge process compares every DUT output against it each cycle, and the
// directed sequence adds literal expectations. Packet-mode checks are built
// when AXIS_FIFO_PACKET_MODE_EN is defined.

module tb_axis_fifo_sync_param;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          m_axis_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [CW-1:0] fill_count;
  logic          almost_full;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [DW:0] q[$];

  axis_fifo_sync_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (AF)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .fill_count    (fill_count),
    .almost_full   (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of complete packets (stored tlast beats) in the model.
  function automatic int model_pkts();
    int n = 0;
    foreach (q[i]) if (q[i][DW]) n++;
    return n;
  endfunction

  // Whether the model's head beat should be offered downstream.
  function automatic bit model_head_valid();
    if (q.size() == 0) return 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    return (model_pkts() != 0) || (q.size() == DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  // Reference model update on each rising edge.
  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (rst) begin
      q.delete();
    end else begin
      do_push = s_tvalid && (q.size() != DEPTH);
      do_pop  = model_head_valid() && m_tready;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({s_tlast, s_tdata});
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tready", 32'(s_axis_tready), 32'(!rst && (q.size() != DEPTH)));
      chk("tvalid", 32'(m_axis_tvalid), 32'(!rst && model_head_valid()));
      chk("fill",   32'(fill_count),    32'(q.size()));
      chk("afull",  32'(almost_full),   32'(!rst && (q.size() >= AF)));
      if (!rst && model_head_valid()) begin
        chk("head_data", 32'(m_axis_tdata), 32'(q[0][DW-1:0]));
        chk("head_last", 32'(m_axis_tlast), 32'(q[0][DW]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;
    int maxf;
    bit acc;
    bit got;

    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tlast = 1'b0;
    m_tready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Reset then idle.
    chk("rst_tready", 32'(s_axis_tready), 32'd1);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_fill",   32'(fill_count),    32'd0);
    chk("rst_afull",  32'(almost_full),   32'd0);

    // Fill to full, no pops; tlast on every fourth beat.
    for (int i = 1; i <= 16; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 16'(i);
      s_tlast  = ((i % 4) == 0);
      tick();
      chk("fill_step", 32'(fill_count), 32'(i));
      if (i == 13) chk("afull_13", 32'(almost_full), 32'd0);
      if (i == 14) chk("afull_14", 32'(almost_full), 32'd1);
    end
    chk("full_tready", 32'(s_axis_tready), 32'd0);
    s_tdata = 16'hDEAD;
    s_tlast = 1'b0;
    tick();
    chk("full_fill17", 32'(fill_count), 32'd16);
    chk("full_head", 32'(m_axis_tdata), 32'h0001);
    s_tvalid = 1'b0;

    // Drain in order.
    m_tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      #1;
      chk("drain_data", 32'(m_axis_tdata), 32'(i));
      chk("drain_last", 32'(m_axis_tlast), 32'((i % 4) == 0));
      tick();
      if (i == 1) chk("tready_back", 32'(s_axis_tready), 32'd1);
    end
    chk("drain_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("drain_fill",   32'(fill_count),    32'd0);
    m_tready = 1'b0;

    // Random valid/ready streaming, 1000 beats.
    sent = 0; recv = 0; cyc = 0; maxf = 0;
    while ((recv < 1000) && (cyc < 20000)) begin
      s_tvalid = (sent < 1000) && ($urandom_range(3) != 0);
      s_tdata  = 16'(sent * 7 + 3);
      s_tlast  = (sent == 999) || ($urandom_range(7) == 0);
      m_tready = ($urandom_range(3) != 0);
      #1;
      acc = s_tvalid && s_axis_tready;
      got = m_axis_tvalid && m_tready;
      tick();
      if (acc) sent++;
      if (got) recv++;
      if (int'(fill_count) > maxf) maxf = int'(fill_count);
      cyc++;
    end
    chk("stream_recv", 32'(recv), 32'd1000);
    chk("stream_maxfill_le16", 32'(maxf <= 16), 32'd1);
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    tick();

    // Five stored beats, then a one-cycle reset with a beat presented.
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 16'(16'h0100 + i);
      s_tlast  = 1'b0;
      tick();
    end
    chk("pre_rst_fill", 32'(fill_count), 32'd5);
    rst = 1'b1;
    s_tdata = 16'hBEEF;
    s_tlast = 1'b1;
    #1;
    chk("in_rst_tready", 32'(s_axis_tready), 32'd0);
    chk("in_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("in_rst_afull",  32'(almost_full),   32'd0);
    tick();
    rst = 1'b0;
    s_tvalid = 1'b0;
    #1;
    chk("post_rst_fill",   32'(fill_count),    32'd0);
    chk("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    s_tvalid = 1'b1;
    s_tdata  = 16'h1234;
    s_tlast  = 1'b1;
    tick();
    s_tvalid = 1'b0;
    chk("post_rst_head", 32'(m_axis_tdata), 32'h1234);
    chk("post_rst_vld",  32'(m_axis_tvalid), 32'd1);
    m_tready = 1'b1;
    tick();
    chk("post_rst_empty", 32'(fill_count), 32'd0);
    m_tready = 1'b0;

`ifdef AXIS_FIFO_PACKET_MODE_EN
    // Packet gating: no head until a tlast beat is stored.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 16'(16'h0A00 + i);
      s_tlast  = 1'b0;
      tick();
      chk("pkt_partial_vld", 32'(m_axis_tvalid), 32'd0);
    end
    s_tdata = 16'h0A03;
    s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0;
    chk("pkt_complete_vld", 32'(m_axis_tvalid), 32'd1);
    chk("pkt_head", 32'(m_axis_tdata), 32'h0A00);

    // Long packet: head offered only once full.
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 16'(16'h0B00 + i);
      s_tlast  = 1'b0;
      tick();
      if (i == 15) chk("pkt_long_15", 32'(m_axis_tvalid), 32'd0);
    end
    s_tvalid = 1'b0;
    chk("pkt_long_full", 32'(m_axis_tvalid), 32'd1);
    do_reset();
`endif

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
